mantissa_normalizer: RTL and testbench

//  Iterative post-add/sub normalizer for the BarelyFLOATing datapath. Takes a raw
//  16-bit mantissa (plus adder carry-out) and exponent, and drives the external
//  16-bit barrel shifter (max 7 positions/cycle) until bit 15 holds the leading one.

---
 rtl/mantissa_normalizer.sv | 152 +++++++++++++++
 tb/tb_mantissa_normalizer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mantissa_normalizer.sv
// Iterative mantissa normalizer: steers an external barrel shifter (up to STEP
// positions per cycle) until the leading one reaches the MSB, adjusting the exponent.
module mantissa_normalizer #(
  parameter int WIDTH = 16,
  parameter int EXP_W = 8,
  parameter int STEP  = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
  input  logic             in_carry,
  input  logic [EXP_W-1:0] in_exp,
  output logic [WIDTH-1:0] sh_value,
  output logic             sh_direction,
  output logic [2:0]       sh_distance,
  input  logic [WIDTH-1:0] sh_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_zero,
  output logic             out_underflow,
  output logic             out_overflow
);

  // state | meaning
  // IDLE  | waiting for an operand, in_ready=1
  // SHIFT | one shifter pass per cycle (right 1 on carry, else left by d)
  // DONE  | result presented until out_ready
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int LZ_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mant, mant_nxt;
  logic [EXP_W-1:0] exp, exp_nxt;
  logic             carry, carry_nxt;
  logic             zero, zero_nxt;
  logic             uf, uf_nxt;
  logic             of, of_nxt;

  logic [LZ_W-1:0]  lz;
  logic [2:0]       dcap, d;
  logic [EXP_W-1:0] exp_lim, exp_dec;

  function automatic logic [LZ_W-1:0] lzc(input logic [WIDTH-1:0] v);
    lzc = LZ_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) lzc = LZ_W'(WIDTH - 1 - i);
  endfunction

  // Shift distance is bounded by the shifter reach and by keeping exp >= 1.
  always_comb begin
    lz = lzc(mant);
    if (lz >= LZ_W'(STEP)) dcap = 3'(STEP);
    else                   dcap = lz[2:0];
    exp_lim = (exp != '0) ? exp - EXP_W'(1) : '0;
    if (exp_lim < EXP_W'(dcap)) d = exp_lim[2:0];
    else                        d = dcap;
    exp_dec = exp - EXP_W'(d);
  end

  always_comb begin
    state_nxt    = state;
    mant_nxt     = mant;
    exp_nxt      = exp;
    carry_nxt    = carry;
    zero_nxt     = zero;
    uf_nxt       = uf;
    of_nxt       = of;
    sh_direction = 1'b0;
    sh_distance  = 3'd0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          mant_nxt  = in_mant;
          carry_nxt = in_carry;
          uf_nxt    = 1'b0;
          of_nxt    = 1'b0;
          if (in_mant == '0 && !in_carry) begin
            exp_nxt   = '0;
            zero_nxt  = 1'b1;
            state_nxt = DONE;
          end else begin
            exp_nxt   = in_exp;
            zero_nxt  = 1'b0;
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (carry) begin
          sh_direction = 1'b1;
          sh_distance  = 3'd1;
          mant_nxt     = sh_result | MSB;
          carry_nxt    = 1'b0;
          if (exp == '1) of_nxt  = 1'b1;
          else           exp_nxt = exp + EXP_W'(1);
          state_nxt    = DONE;
        end else begin
          sh_distance = d;
          mant_nxt    = sh_result;
          exp_nxt     = exp_dec;
          uf_nxt      = (lz != LZ_W'(d));
          if (lz == LZ_W'(d) || exp_dec <= EXP_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
          zero_nxt  = 1'b0;
          uf_nxt    = 1'b0;
          of_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      mant  <= '0;
      exp   <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
      uf    <= 1'b0;
      of    <= 1'b0;
    end else begin
      state <= state_nxt;
      mant  <= mant_nxt;
      exp   <= exp_nxt;
      carry <= carry_nxt;
      zero  <= zero_nxt;
      uf    <= uf_nxt;
      of    <= of_nxt;
    end
  end

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);
  assign sh_value      = mant;
  assign out_mant      = mant;
  assign out_exp       = exp;
  assign out_zero      = zero;
  assign out_underflow = uf;
  assign out_overflow  = of;

endmodule

// File: tb/tb_mantissa_normalizer.sv
// Directed bench for mantissa_normalizer with a behavioural barrel shifter model.
module tb_mantissa_normalizer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_mant = '0;
  logic        in_carry = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [15:0] sh_value;
  logic        sh_direction;
  logic [2:0]  sh_distance;
  logic [15:0] sh_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_zero, out_underflow, out_overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign sh_result = sh_direction ? (sh_value >> sh_distance) : (sh_value << sh_distance);

  mantissa_normalizer dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_carry(in_carry), .in_exp(in_exp),
    .sh_value(sh_value), .sh_direction(sh_direction), .sh_distance(sh_distance),
    .sh_result(sh_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_zero(out_zero),
    .out_underflow(out_underflow), .out_overflow(out_overflow)
  );

  typedef struct {
    logic [15:0] mant;
    logic        carry;
    logic [7:0]  exp;
    logic [15:0] emant;
    logic [7:0]  eexp;
    logic        ez, eu, eo;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    check({tag, " in_ready before accept"}, int'(in_ready), 1);
    in_mant  = v.mant;
    in_carry = v.carry;
    in_exp   = v.exp;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"},   lat, v.lat);
    check({tag, " out_mant"},  int'(out_mant), int'(v.emant));
    check({tag, " out_exp"},   int'(out_exp), int'(v.eexp));
    check({tag, " out_zero"},  int'(out_zero), int'(v.ez));
    check({tag, " underflow"}, int'(out_underflow), int'(v.eu));
    check({tag, " overflow"},  int'(out_overflow), int'(v.eo));
    check({tag, " in_ready in DONE"}, int'(in_ready), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " back to idle"}, int'(in_ready), 1);
    check({tag, " valid cleared"}, int'(out_valid), 0);
    check({tag, " flags cleared"}, int'({out_zero, out_underflow, out_overflow}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //        mant      c     exp     emant     eexp    z     u     o    lat
    vecs[0]  = '{16'h8000, 1'b0, 8'd10,  16'h8000, 8'd10,  1'b0, 1'b0, 1'b0, 2};
    vecs[1]  = '{16'h0001, 1'b0, 8'd20,  16'h8000, 8'd5,   1'b0, 1'b0, 1'b0, 4};
    vecs[2]  = '{16'h4000, 1'b1, 8'd10,  16'hA000, 8'd11,  1'b0, 1'b0, 1'b0, 2};
    vecs[3]  = '{16'h4000, 1'b1, 8'd255, 16'hA000, 8'd255, 1'b0, 1'b0, 1'b1, 2};
    vecs[4]  = '{16'h0100, 1'b0, 8'd3,   16'h0400, 8'd1,   1'b0, 1'b1, 1'b0, 2};
    vecs[5]  = '{16'h0000, 1'b0, 8'd77,  16'h0000, 8'd0,   1'b1, 1'b0, 1'b0, 1};
    vecs[6]  = '{16'h0F00, 1'b0, 8'd100, 16'hF000, 8'd96,  1'b0, 1'b0, 1'b0, 2};
    vecs[7]  = '{16'h0001, 1'b0, 8'd9,   16'h0100, 8'd1,   1'b0, 1'b1, 1'b0, 3};
    vecs[8]  = '{16'h0000, 1'b1, 8'd10,  16'h8000, 8'd11,  1'b0, 1'b0, 1'b0, 2};
    vecs[9]  = '{16'h1234, 1'b0, 8'd0,   16'h1234, 8'd0,   1'b0, 1'b1, 1'b0, 2};
    vecs[10] = '{16'h00FF, 1'b0, 8'd8,   16'h7F80, 8'd1,   1'b0, 1'b1, 1'b0, 2};

    #12;
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset outputs", int'({out_mant, out_exp, out_zero, out_underflow, out_overflow}), 0);
    check("reset sh_distance", int'(sh_distance), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: DONE must hold its result and ignore new operands.
    begin
      logic [15:0] m0;
      logic [7:0]  e0;
      @(negedge clk);
      in_mant = 16'h0F00; in_exp = 8'd50; in_carry = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_mant = 16'h0003; in_exp = 8'd200;
      repeat (2) @(negedge clk);
      check("hold reached done", int'(out_valid), 1);
      m0 = out_mant; e0 = out_exp;
      check("hold mant value", int'(m0), 16'hF000);
      check("hold exp value", int'(e0), 46);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        check($sformatf("hold c%0d valid", c), int'(out_valid), 1);
        check($sformatf("hold c%0d mant", c), int'(out_mant), 16'hF000);
        check($sformatf("hold c%0d exp", c), int'(out_exp), 46);
        check($sformatf("hold c%0d in_ready", c), int'(in_ready), 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("hold released", int'(in_ready), 1);
    end

    // Reset during SHIFT discards the operand.
    @(negedge clk);
    in_mant = 16'h0001; in_exp = 8'd20; in_carry = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre-reset in SHIFT", int'(in_ready), 0);
    reset_n = 1'b0;
    #1;
    check("midreset out_valid", int'(out_valid), 0);
    check("midreset in_ready", int'(in_ready), 1);
    check("midreset out_mant", int'(out_mant), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post-reset no output", int'(out_valid), 0);
    run_op(vecs[1], "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
